// File: rtl/wiscsc15_mem_arb_if.sv
// Bundle of the pipeline-side request/ack signals and the memory-macro port
// shared by the unified-memory arbiter and whatever drives it.
interface wiscsc15_mem_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;

    modport slave (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, stall,
               mem_en, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, stall,
               mem_en, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/wiscsc15_mem_arb.sv
// Serialises instruction-fetch and data-memory accesses onto one fixed-latency
// single-port memory; data side has fixed priority over fetch.
module wiscsc15_mem_arb #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    wiscsc15_mem_arb_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, ACK} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t            state_q;
    owner_t            owner_q;
    logic [3:0]        cnt_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              err_q;

    logic dm_req;
    assign dm_req = bus.dm_read | bus.dm_write;

    // NOTE: every register here is state, so it is assigned with <= only;
    // the one-cycle pulses default low at the top and are raised in one state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_en_q <= 1'b0;
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dm_req) begin
                        owner_q     <= OWN_DM;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        mem_we_q    <= bus.dm_write;
                        mem_en_q    <= 1'b1;
                        state_q     <= ISSUE;
                        // Read+write together is illegal; it is serviced as a write.
                        if (bus.dm_read && bus.dm_write) err_q <= 1'b1;
                    end else if (bus.if_req) begin
                        owner_q    <= OWN_IF;
                        mem_addr_q <= bus.if_addr;
                        mem_we_q   <= 1'b0;
                        mem_en_q   <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= 4'(MEM_LAT - 1);
                    state_q <= (MEM_LAT == 1) ? CAPT : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= CAPT;
                end
                CAPT: begin
                    if (owner_q == OWN_DM) begin
                        if (!mem_we_q) dm_rdata_q <= bus.mem_rdata;
                        dm_ack_q <= 1'b1;
                    end else begin
                        if_rdata_q <= bus.mem_rdata;
                        if_ack_q   <= 1'b1;
                    end
                    state_q <= ACK;
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.err       = err_q;
    assign bus.stall     = (dm_req & ~dm_ack_q) | (bus.if_req & ~if_ack_q);
endmodule

// File: tb/tb_wiscsc15_mem_arb.sv
// Self-checking bench: vector table with an ack scoreboard on a MEM_LAT=2 build,
// plus hand sequences for withdrawal, reset abort and MEM_LAT=1/4 builds.
module tb_wiscsc15_mem_arb;
    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wiscsc15_mem_arb_if #(.ADDR_W(16), .DATA_W(16)) b2 ();
    wiscsc15_mem_arb_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
    wiscsc15_mem_arb_if #(.ADDR_W(16), .DATA_W(16)) b4 ();

    wiscsc15_mem_arb #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT)) dut (.clk(clk), .rst(rst), .bus(b2));
    wiscsc15_mem_arb #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    wiscsc15_mem_arb #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    // Fixed-latency memory for the main build; returns DEAD outside the valid cycle.
    logic [15:0] mdl_mem [1024];
    bit          mdl_wv  [1024];
    logic [15:0] pipe_d  [MEM_LAT];
    logic        pipe_v  [MEM_LAT];
    always @(posedge clk) begin
        if (b2.mem_en && b2.mem_we) begin
            mdl_mem[b2.mem_addr[9:0]] <= b2.mem_wdata;
            mdl_wv[b2.mem_addr[9:0]]  <= 1'b1;
        end
        pipe_d[0] <= mdl_wv[b2.mem_addr[9:0]] ? mdl_mem[b2.mem_addr[9:0]] : init_val(b2.mem_addr);
        pipe_v[0] <= b2.mem_en && !b2.mem_we;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
    end
    assign b2.mem_rdata = (pipe_v[MEM_LAT-1] === 1'b1) ? pipe_d[MEM_LAT-1] : 16'hDEAD;
    assign b1.mem_rdata = init_val(b1.mem_addr);
    assign b4.mem_rdata = init_val(b4.mem_addr);

    // Reference contents as the requesters expect to see them.
    logic [15:0] ref_mem [1024];
    bit          ref_wv  [1024];
    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_wv[a[9:0]] ? ref_mem[a[9:0]] : init_val(a);
    endfunction

    typedef struct {
        logic ifr; logic [15:0] ia;
        logic dr; logic dw; logic [15:0] da; logic [15:0] dwd;
        logic exp_err;
    } vec_t;

    typedef struct {
        bit is_dm; bit we; logic [15:0] addr; logic [15:0] wdata;
        logic [15:0] data; int issue; int ack;
    } sb_t;

    sb_t         sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_if = 16'h0;
    logic [15:0] exp_dm = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"},    b2.mem_en,    0);
        check({tag, "_mem_we"},    b2.mem_we,    0);
        check({tag, "_mem_addr"},  b2.mem_addr,  0);
        check({tag, "_mem_wdata"}, b2.mem_wdata, 0);
        check({tag, "_if_ack"},    b2.if_ack,    0);
        check({tag, "_dm_ack"},    b2.dm_ack,    0);
        check({tag, "_if_rdata"},  b2.if_rdata,  0);
        check({tag, "_dm_rdata"},  b2.dm_rdata,  0);
        check({tag, "_err"},       b2.err,       0);
    endtask

    task automatic pop_check(input bit is_dm, input int cyc);
        sb_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_ack: ack from %s at cycle %0d, none expected", is_dm ? "dm" : "if", cyc);
            return;
        end
        e = sb.pop_front();
        check("ack_owner", 32'(is_dm), 32'(e.is_dm));
        check("ack_cycle", cyc, e.ack);
        if (is_dm) begin
            check("dm_rdata", b2.dm_rdata, e.data);
            check("if_rdata_hold", b2.if_rdata, exp_if);
        end else begin
            check("if_rdata", b2.if_rdata, e.data);
            check("dm_rdata_hold", b2.dm_rdata, exp_dm);
        end
    endtask

    task automatic run_vec(input vec_t v);
        sb_t e;
        int n = 0, cyc = 0, acks = 0, st_cnt = 0, en_cnt = 0, last = 0, base = 0;
        bit drop_if = 0, drop_dm = 0;
        if (v.dr || v.dw) begin
            e.is_dm = 1; e.we = v.dw; e.addr = v.da; e.wdata = v.dwd;
            e.data = v.dw ? exp_dm : ref_rd(v.da);
            if (v.dw) begin ref_mem[v.da[9:0]] = v.dwd; ref_wv[v.da[9:0]] = 1'b1; end
            exp_dm = e.data;
            e.issue = 1; e.ack = MEM_LAT + 2;
            sb.push_back(e); n++; last = e.ack; base = MEM_LAT + 3;
        end
        if (v.ifr) begin
            e.is_dm = 0; e.we = 0; e.addr = v.ia; e.wdata = 16'h0;
            e.data = ref_rd(v.ia);
            e.issue = base + 1; e.ack = base + MEM_LAT + 2;
            sb.push_back(e); n++; last = e.ack;
        end
        b2.if_req = v.ifr; b2.if_addr = v.ia;
        b2.dm_read = v.dr; b2.dm_write = v.dw; b2.dm_addr = v.da; b2.dm_wdata = v.dwd;
        #1;
        while (1) begin
            if (b2.stall) st_cnt++;
            if (b2.mem_en) begin
                en_cnt++;
                if (sb.size() > 0) begin
                    check("issue_cycle", cyc, sb[0].issue);
                    check("mem_we", 32'(b2.mem_we), 32'(sb[0].we));
                    check("mem_addr", b2.mem_addr, sb[0].addr);
                    if (sb[0].we) check("mem_wdata", b2.mem_wdata, sb[0].wdata);
                end
            end
            if (b2.if_ack) begin
                acks++; drop_if = 1;
                if (sb.size() > 0 && !sb[0].is_dm) exp_if = sb[0].data;
                pop_check(1'b0, cyc);
            end
            if (b2.dm_ack) begin acks++; drop_dm = 1; pop_check(1'b1, cyc); end
            if (acks >= n || cyc >= 40) break;
            @(posedge clk); #1; cyc++;
            if (drop_if) b2.if_req = 1'b0;
            if (drop_dm) begin b2.dm_read = 1'b0; b2.dm_write = 1'b0; end
            #1;
        end
        check("ack_count", acks, n);
        check("stall_cycles", st_cnt, last);
        check("mem_en_pulses", en_cnt, n);
        check("err_flag", b2.err, v.exp_err);
        @(posedge clk); #1;
        b2.if_req = 0; b2.dm_read = 0; b2.dm_write = 0;
        #1;
        sb.delete();
    endtask

    vec_t vecs[8];

    initial begin
        int ack_at, en_cnt, a1, a4, n1, n4, e1, e4;
        vecs[0] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0300, 16'h1234, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 16'h0041, 1'b0, 1'b1, 16'h0041, 16'hCAFE, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0050, 16'h7777, 1'b1};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b1};

        b2.if_req = 0; b2.if_addr = 0; b2.dm_read = 0; b2.dm_write = 0; b2.dm_addr = 0; b2.dm_wdata = 0;
        b1.if_req = 0; b1.if_addr = 0; b1.dm_read = 0; b1.dm_write = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
        b4.if_req = 0; b4.if_addr = 0; b4.dm_read = 0; b4.dm_write = 0; b4.dm_addr = 0; b4.dm_wdata = 0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        #1;
        check("idle_stall", b2.stall, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Withdrawal and address change mid-transaction are ignored.
        b2.dm_read = 1; b2.dm_addr = 16'h0200;
        ack_at = -1; en_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin b2.dm_addr = 16'h0300; b2.dm_read = 0; #1; end
            if (b2.mem_en) en_cnt++;
            if (c <= 4) check("mem_addr_hold", b2.mem_addr, 16'h0200);
            if (b2.dm_ack) begin ack_at = c; check("withdraw_dm_rdata", b2.dm_rdata, ref_rd(16'h0200)); end
        end
        check("withdraw_ack_cycle", ack_at, MEM_LAT + 2);
        check("withdraw_mem_en_pulses", en_cnt, 1);

        // Reset during WAIT aborts; a held fetch is re-granted afterwards.
        b2.if_req = 1; b2.if_addr = 16'h0040;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("reset_hold_if_ack", b2.if_ack, 0);
            check("reset_hold_mem_en", b2.mem_en, 0);
        end
        rst = 1'b0;
        ack_at = -1;
        for (int c = 0; c <= 10; c++) begin
            #1;
            if (b2.if_ack && ack_at < 0) begin ack_at = c; check("regrant_if_rdata", b2.if_rdata, 16'hBEEF); end
            @(posedge clk); #1;
            if (ack_at >= 0) b2.if_req = 0;
        end
        check("regrant_ack_cycle", ack_at, MEM_LAT + 2);

        // MEM_LAT=1 and MEM_LAT=4 builds side by side.
        b1.if_req = 1; b1.if_addr = 16'h0123;
        b4.if_req = 1; b4.if_addr = 16'h0123;
        #1;
        a1 = -1; a4 = -1; n1 = 0; n4 = 0; e1 = 0; e4 = 0;
        for (int c = 0; c <= 12; c++) begin
            if (b1.mem_en) e1++;
            if (b4.mem_en) e4++;
            if (b1.if_ack) begin n1++; a1 = c; check("lat1_rdata", b1.if_rdata, 16'h0123 ^ 16'h5A5A); end
            if (b4.if_ack) begin n4++; a4 = c; check("lat4_rdata", b4.if_rdata, 16'h0123 ^ 16'h5A5A); end
            @(posedge clk); #1;
            if (a1 >= 0) b1.if_req = 0;
            if (a4 >= 0) b4.if_req = 0;
        end
        check("lat1_ack_cycle", a1, 3);
        check("lat4_ack_cycle", a4, 6);
        check("lat1_ack_count", n1, 1);
        check("lat4_ack_count", n4, 1);
        check("lat1_mem_en_pulses", e1, 1);
        check("lat4_mem_en_pulses", e4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wiscsc15_mem_arb.md
Name: wiscsc15_mem_arb

Overview:
- Arbiter and sequencer that shares one single-port, fixed-latency unified memory between the instruction-fetch requester and the data-memory requester.
- The data-memory requester is driven by the controller's dm_read/dm_write/dm_addr/dm_in decode.
- Serialises accesses, holds the pipeline through the stall output, and returns read data with a one-cycle ack pulse.
- Sits between the pipeline (fetch stage, memory stage) and the memory macro.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- if_req  input  1  fetch request, level, held until if_ack
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  DATA_W  fetched instruction, valid when if_ack=1
- if_ack  output  1  fetch complete, one-cycle pulse
- dm_read  input  1  data read request, level, held until dm_ack
- dm_write  input  1  data write request, level, held until dm_ack
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_rdata  output  DATA_W  load data, valid when dm_ack=1
- dm_ack  output  1  data access complete, one-cycle pulse
- stall  output  1  pipeline hold
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable, qualified by mem_en
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- err  output  1  sticky protocol-error flag

Behaviour:
- Reset: all of the following go to 0: state=IDLE, counter, mem_en, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, err. Reset asserted mid-transaction aborts it immediately; no ack is issued for that transaction.
- dm_req = dm_read | dm_write.
- FSM states: IDLE, ISSUE, WAIT, CAPT, ACK. Exactly one transaction in flight at any time.
- IDLE:
  - If dm_req, grant DM: latch owner=DM, addr=dm_addr, wdata=dm_wdata, we=dm_write. Go to ISSUE.
  - Else if if_req, grant IF: latch owner=IF, addr=if_addr, we=0. Go to ISSUE.
  - Else stay in IDLE.
  - Priority is fixed: DM over IF.
- ISSUE: mem_en=1 for exactly this cycle; mem_we/mem_addr/mem_wdata come from the latched values. Load counter=MEM_LAT-1. Go to CAPT if MEM_LAT=1, else WAIT.
- WAIT: decrement counter each cycle. Go to CAPT when counter reaches 1. WAIT therefore lasts MEM_LAT-1 cycles.
- CAPT: this cycle is ISSUE+MEM_LAT. Register mem_rdata into the owner's rdata register; for a write, the owner's rdata keeps its previous value. Go to ACK.
- ACK: owner's ack=1 for exactly this cycle; no new grant is made in this state. Go to IDLE.
  - The requester drops or changes its request in the cycle after ack, so the following IDLE sees fresh request levels.
- Latency: request sampled in IDLE at cycle 0 → ack at cycle MEM_LAT+2. Back-to-back requests run one transaction per MEM_LAT+3 cycles.
- mem_en, mem_we, mem_addr, mem_wdata are registered; mem_addr/mem_wdata hold the latched values from ISSUE through ACK.
- Requester inputs are ignored after grant. Address/data changes or request withdrawal mid-transaction have no effect; the transaction completes and ack still pulses.
- stall = (dm_req & ~dm_ack) | (if_req & ~if_ack), combinational from registered acks. stall is 0 when no request is pending.
- err is set (sticky until reset) when dm_read & dm_write are both 1 in IDLE. Such a request is serviced as a write.
- rdata outputs hold their value between acks.

Test Plan:
- MEM_LAT=2; mem model returns 16'hBEEF at 0x0040. Assert if_req, if_addr=0x0040 at cycle 0 → mem_en=1, mem_we=0 at cycle 1; if_ack=1 with if_rdata=16'hBEEF at cycle 4; stall=1 in cycles 0–3.
- Assert if_req (addr 0x0010) and dm_read (addr 0x0200) together → DM served first (dm_ack at cycle 4), IF issued at cycle 6, if_ack at cycle 9.
- dm_write, addr 0x0300, data 16'h1234 → one mem_en pulse with mem_we=1, addr 0x0300, wdata 0x1234; dm_ack at cycle 4; a later dm_read of 0x0300 returns 0x1234; if_rdata unchanged.
- MEM_LAT=1 build → ack at cycle 3; MEM_LAT=4 build → ack at cycle 6. Exactly one mem_en pulse per transaction in both.
- Assert rst during WAIT → all outputs 0 the same cycle, no ack issued; after release, a held if_req is re-granted from IDLE.
- dm_read=dm_write=1 → err=1 and stays 1; a write is performed. Change dm_addr during WAIT → mem_addr unchanged.
